// File: rtl/mem_responder.sv
// Memory-mapped responder: aliased RAM, LED/switch registers, TX byte FIFO and status.
// Define MEM_RESPONDER_TIMER_EN to add the free-running TIMER register at 0xF004.
module mem_responder #(
    parameter int unsigned RAM_AW   = 12,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        write,
    input  logic        read,
    output logic [15:0] rdata,
    output logic        rdata_valid,
    output logic        bus_err,
    input  logic [9:0]  sw,
    output logic [9:0]  led,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready
);

    localparam int unsigned PW = $clog2(TX_DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FullCount = CW'(TX_DEPTH);

    logic [15:0]   mem [0:(1 << RAM_AW) - 1];
    logic [7:0]    fifo [0:TX_DEPTH - 1];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [9:0]    led_q, sw_s1, sw_s2;
    logic [15:0]   rd_val;

    logic is_ram, is_led, is_sw, is_tx, is_status, is_timer, mapped;
    logic full, empty, push_req, push_ok, pop, overflow, status_rd;

    assign is_ram    = addr < 16'hF000;
    assign is_led    = addr == 16'hF000;
    assign is_sw     = addr == 16'hF001;
    assign is_tx     = addr == 16'hF002;
    assign is_status = addr == 16'hF003;
`ifdef MEM_RESPONDER_TIMER_EN
    logic [15:0] timer;
    assign is_timer = addr == 16'hF004;
`else
    assign is_timer = 1'b0;
`endif
    assign mapped = is_ram | is_led | is_sw | is_tx | is_status | is_timer;

    assign full      = count == FullCount;
    assign empty     = count == '0;
    assign tx_valid  = !empty;
    assign pop       = tx_valid & tx_ready;
    assign push_req  = write & is_tx;
    // A push into a full FIFO still fits if the head leaves in the same cycle.
    assign push_ok   = push_req & (!full | pop);
    assign overflow  = push_req & full & !pop;
    assign status_rd = read & is_status;

    assign tx_data = tx_valid ? fifo[rd_ptr] : 8'h00;
    assign led     = led_q;

    always_comb begin
        rd_val = 16'h0000;
        if (is_ram)         rd_val = mem[addr[RAM_AW-1:0]];
        else if (is_led)    rd_val = {6'b0, led_q};
        else if (is_sw)     rd_val = {6'b0, sw_s2};
        else if (is_status) rd_val = {{(13 - CW){1'b0}}, count, ovf, empty, full};
`ifdef MEM_RESPONDER_TIMER_EN
        else if (is_timer)  rd_val = timer;
`endif
    end

    // Storage arrays carry no reset; writes in a reset cycle are dropped.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (write && is_ram) mem[addr[RAM_AW-1:0]] <= wdata;
            if (push_ok)         fifo[wr_ptr] <= wdata[7:0];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            rdata       <= 16'h0000;
            rdata_valid <= 1'b0;
            bus_err     <= 1'b0;
            led_q       <= 10'h000;
            sw_s1       <= 10'h000;
            sw_s2       <= 10'h000;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            ovf         <= 1'b0;
        end else begin
            rdata       <= read ? rd_val : 16'h0000;
            rdata_valid <= read;
            bus_err     <= (read | write) & !mapped;
            sw_s1       <= sw;
            sw_s2       <= sw_s1;
            if (write && is_led) led_q <= wdata[9:0];
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            unique case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            ovf <= (ovf & !status_rd) | overflow;
        end
    end

`ifdef MEM_RESPONDER_TIMER_EN
    always_ff @(posedge clock) begin
        if (reset)                  timer <= 16'h0000;
        else if (write && is_timer) timer <= 16'h0000;
        else                        timer <= timer + 16'h0001;
    end
`endif

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter RAM_AW, default 12: RAM word-address width; RAM holds 2^RAM_AW 16-bit words.
REQ-002 Parameter TX_DEPTH, default 4: TX FIFO entries; power of two, minimum 2.
REQ-003 clock  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 addr  in  16  word address from CPU datapath.
REQ-006 wdata  in  16  write data.
REQ-007 write  in  1  write strobe; one access per cycle high.
REQ-008 read  in  1  read strobe; one access per cycle high.
REQ-009 rdata  out  16  read data.
REQ-010 rdata_valid  out  1  read data qualifier.
REQ-011 bus_err  out  1  one-cycle pulse flagging an unmapped access.
REQ-012 sw  in  10  asynchronous switch inputs.
REQ-013 led  out  10  LED register.
REQ-014 tx_data  out  8  FIFO head byte.
REQ-015 tx_valid  out  1  FIFO non-empty.
REQ-016 tx_ready  in  1  sink accepts head byte when tx_valid and tx_ready are both high.

Function
REQ-017 Map: 0x0000-0xEFFF RAM, aliased on addr[RAM_AW-1:0]; 0xF000 LED RW; 0xF001 SW RO; 0xF002 TX WO; 0xF003 STATUS RO; 0xF004 TIMER RW; 0xF005-0xFFFF unmapped.
REQ-018 Read latency is fixed at 1 cycle: read high in cycle N -> rdata and rdata_valid=1 in cycle N+1 only.
REQ-019 rdata is 0 in every cycle where rdata_valid=0.
REQ-020 Writes take effect at the edge ending the strobe cycle.
REQ-021 When read and write are both high, the write is performed and rdata returns the pre-write value (read-before-write).
REQ-022 LED read returns {6'b0, led}; a write loads wdata[9:0] into led.
REQ-023 SW read returns {6'b0, sw}, with sw passed through a 2-flop synchronizer (2-cycle input lag).
REQ-024 A TX write pushes wdata[7:0]; a TX read returns 0 with no bus_err.
REQ-025 A push when the FIFO is full is dropped and sets sticky ovf, except that a push coinciding with a pop while full is accepted (count stays TX_DEPTH).
REQ-026 A pop occurs on tx_valid and tx_ready; the FIFO is first-in first-out and its pointers wrap modulo TX_DEPTH.
REQ-027 Simultaneous push and pop when empty: the pushed byte appears on tx_data the next cycle with tx_valid=1 and count=1.
REQ-028 STATUS = {count zero-extended to bits 15:3, ovf bit2, empty bit1, full bit0}.
REQ-029 A STATUS read clears ovf after sampling; an overflow in the same cycle as the read leaves ovf=1.
REQ-030 A STATUS write is ignored with no bus_err.
REQ-031 An unmapped read returns rdata=0 with rdata_valid=1 and bus_err=1 in cycle N+1.
REQ-032 An unmapped write changes no state and pulses bus_err=1 in cycle N+1.

Reset
REQ-033 Reset while high, in the next cycle and thereafter until release: rdata=0, rdata_valid=0, bus_err=0, led=0, tx_valid=0, tx_data=0, FIFO count=0, ovf=0, timer=0, synchronizer flops=0.
REQ-034 RAM contents are not reset.
REQ-035 A read or write accepted in the same cycle as reset is discarded; no rdata_valid follows.

Configuration
REQ-036 Macro MEM_RESPONDER_TIMER_EN defined: TIMER is a 16-bit free-running counter, +1 per cycle, wrapping 0xFFFF->0x0000; a read returns its value at the read cycle; a write of any data clears it to 0 at that edge.
REQ-037 MEM_RESPONDER_TIMER_EN undefined: no counter logic is present and 0xF004 behaves as unmapped per REQ-031/REQ-032.

Verification
REQ-038 Write 0x1234 to 0x0010, then read 0x0010 -> rdata=0x1234, rdata_valid=1 exactly one cycle later; read of 0x1010 (RAM_AW=12 alias) -> 0x1234.
REQ-039 tx_ready=0; push 0x41,0x42,0x43,0x44,0x45 -> STATUS=0x0021 (count 4, ovf 0, full 1) after the 4th push, then 0x0025 after the 5th; a second STATUS read -> 0x0021.
REQ-040 From REQ-039, hold tx_ready=1 -> tx_data 0x41,0x42,0x43,0x44 on consecutive cycles, then tx_valid=0 and STATUS=0x0002.
REQ-041 FIFO full with tx_ready=1, push 0x55 in the same cycle -> no ovf, count stays 4, and 0x55 is popped 4th.
REQ-042 Read 0xF00A and write 0xFFFF -> each gives bus_err=1 for one cycle, the read gives rdata=0, and no LED or RAM change.
REQ-043 With TIMER_EN: write 0xF004, wait 9 cycles, read -> 0x0009 (counted per REQ-036); without TIMER_EN: read 0xF004 -> 0 plus bus_err; reset asserted mid-read -> rdata_valid stays 0.
